seg_display_scan: RTL and testbench
===================================

SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clock cycles each digit stays lit (legal range >= 2).
REQ-002 Parameter DEB_CYC, default 1000000, consecutive stable cycles required to accept a change on addr_up (legal range >= 2).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mode  input  3  display source select (REQ-012).
REQ-006 syscall_out  input  32  CPU syscall display latch.
REQ-007 pc  input  32  CPU program counter.
REQ-008 memory_out  input  32  data memory word at addr_debug.
REQ-009 total_cycles, jump_cycles, branch_cycles, branch_sucess_cycles  input  16 each  CPU statistics counters.
REQ-010 addr_up  input  1  raw push-button, asynchronous to clk, active-high.
REQ-011 an  output  8  digit enables, active-low, one-hot; seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low; addr_debug  output  12  data memory word index.

Function
REQ-012 Source select: 0 syscall_out; 1 pc; 2 memory_out; 3 {16'h0,total_cycles}; 4 {16'h0,jump_cycles}; 5 {16'h0,branch_cycles}; 6 {16'h0,branch_sucess_cycles}; 7 {20'h0,addr_debug}.
REQ-013 Scan counter scnt counts 0..SCAN_DIV-1, +1 per cycle, wraps to 0.
REQ-014 Digit index dig (3 bits) increments when scnt==SCAN_DIV-1, wraps 7->0.
REQ-015 Frame boundary = cycle with scnt==SCAN_DIV-1 and dig==7; shadow register (32 bits) loads the REQ-012 selected value only at frame boundary.
REQ-016 Mode or source-value changes mid-frame never alter the displayed frame; they appear from the next frame.
REQ-017 an and seg are registered: an = ~(8'b1<<dig) and seg = decode(shadow[4*dig+3:4*dig]), one cycle after dig/shadow.
REQ-018 Digit 0 = least significant nibble, shown on an[0].
REQ-019 Decode: standard hex 0-F, active-low; 0->8'hC0, 1->F9, 2->A4, 3->B0, 4->99, 5->92, 6->82, 7->F8, 8->80, 9->90, A->88, b->83, C->C6, d->A1, E->86, F->8E; dp always off.
REQ-020 addr_up passes a two-flop synchronizer before debounce.
REQ-021 Debouncer: stable state btn_s; counter dcnt resets to 0 whenever synchronized input equals btn_s, else increments; when dcnt reaches DEB_CYC-1 btn_s toggles and dcnt clears.
REQ-022 Pulses shorter than DEB_CYC cycles change nothing.
REQ-023 A 0->1 transition of btn_s increments addr_debug by 1 exactly once; holding the button gives no further increments; 1->0 has no effect.
REQ-024 addr_debug wraps 4095->0.
REQ-025 Block never stalls; no handshake; outputs valid every cycle.

Reset
REQ-026 While reset is high: scnt=0, dig=0, shadow=0, dcnt=0, btn_s=0, synchronizer flops=0, addr_debug=0, an=8'hFF, seg=8'hFF.
REQ-027 First cycle after reset release: an=8'hFE, seg=8'hC0 (shadow 0).
REQ-028 Reset asserted mid-frame or mid-debounce discards all progress; no partial increment of addr_debug.

Verification (SCAN_DIV=4, DEB_CYC=3)
REQ-029 Reset, mode=1, pc=32'h0000_0040 held -> frame 0 shows 00000000 (an cycles FE,FD,...,7F, 4 cycles each); after first boundary digit 1 shows seg=8'h99, digit 0 shows 8'hC0, others 8'hC0.
REQ-030 mode=0, syscall_out=32'h1234ABCD; change mode to 2 mid-frame -> current frame unaffected; following frame shows digits 0..7 = D,C,B,A,4,3,2,1 (8'hA1,C6,83,88,99,B0,A4,F9); next frame shows memory_out.
REQ-031 addr_up high 2 cycles then low -> addr_debug stays 0; high 20 cycles -> addr_debug=1 exactly once, ~5 cycles after rise (2 sync + 3 debounce).
REQ-032 addr_debug preset via 4095 clean presses, one more press -> addr_debug=0; mode=7 then displays 00000000 next frame.
REQ-033 Assert reset for 1 cycle while dig=5 and dcnt=1 -> all state per REQ-026, an=8'hFF that cycle, an=8'hFE next cycle, addr_debug unchanged at 0.
REQ-034 mode=3, total_cycles=16'hFFFF -> upper four digits show 8'hC0, lower four 8'h8E.

Source files
------------

// File: rtl/seg_display_scan.sv
// seg_display_scan
//   Multiplexes one of eight 32-bit CPU/debug values onto an 8-digit
//   7-segment display, one digit lit at a time. The shown value is latched
//   only at frame boundaries, so a frame is never torn. A debounced push
//   button steps the data-memory debug address.
//
// Ports
//   clk                  system clock, rising edge
//   reset                synchronous, active-high
//   mode                 display source select (0..7)
//   syscall_out, pc      CPU values (32 bits)
//   memory_out           data memory word at addr_debug
//   total_cycles, jump_cycles, branch_cycles, branch_sucess_cycles
//                        16-bit statistics counters
//   addr_up              raw push-button, asynchronous, active-high
//   an                   digit enables, active-low one-hot
//   seg                  segments {dp,g,f,e,d,c,b,a}, active-low
//   addr_debug           data memory word index
module seg_display_scan #(
   parameter int unsigned SCAN_DIV = 100000,
   parameter int unsigned DEB_CYC  = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  mode,
   input  logic [31:0] syscall_out,
   input  logic [31:0] pc,
   input  logic [31:0] memory_out,
   input  logic [15:0] total_cycles,
   input  logic [15:0] jump_cycles,
   input  logic [15:0] branch_cycles,
   input  logic [15:0] branch_sucess_cycles,
   input  logic        addr_up,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic [11:0] addr_debug
);

   localparam int unsigned SCW = $clog2(SCAN_DIV);
   localparam int unsigned DCW = $clog2(DEB_CYC);
   localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
   localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYC - 1);

   logic [SCW-1:0] r_scnt;
   logic [2:0]     r_dig;
   logic [31:0]    r_shadow;
   logic [7:0]     r_an;
   logic [7:0]     r_seg;
   logic           r_sync1;
   logic           r_sync2;
   logic           r_btn_s;
   logic [DCW-1:0] r_dcnt;
   logic [11:0]    r_addr;

   logic           w_scan_wrap;
   logic           w_frame_end;
   logic [31:0]    w_sel;
   logic [3:0]     w_nib;
   logic [7:0]     w_dec;
   logic           w_deb_diff;
   logic           w_deb_fire;

   assign w_scan_wrap = (r_scnt == SCAN_LAST);
   assign w_frame_end = w_scan_wrap && (r_dig == 3'd7);

   always_comb begin
      w_sel = '0;
      case (mode)
         3'd0:    w_sel = syscall_out;
         3'd1:    w_sel = pc;
         3'd2:    w_sel = memory_out;
         3'd3:    w_sel = {16'h0, total_cycles};
         3'd4:    w_sel = {16'h0, jump_cycles};
         3'd5:    w_sel = {16'h0, branch_cycles};
         3'd6:    w_sel = {16'h0, branch_sucess_cycles};
         default: w_sel = {20'h0, r_addr};
      endcase
   end

   assign w_nib = r_shadow[{r_dig, 2'b00} +: 4];

   // Hex decode, active-low, dp kept dark
   always_comb begin
      w_dec = 8'hFF;
      case (w_nib)
         4'h0:    w_dec = 8'hC0;
         4'h1:    w_dec = 8'hF9;
         4'h2:    w_dec = 8'hA4;
         4'h3:    w_dec = 8'hB0;
         4'h4:    w_dec = 8'h99;
         4'h5:    w_dec = 8'h92;
         4'h6:    w_dec = 8'h82;
         4'h7:    w_dec = 8'hF8;
         4'h8:    w_dec = 8'h80;
         4'h9:    w_dec = 8'h90;
         4'hA:    w_dec = 8'h88;
         4'hB:    w_dec = 8'h83;
         4'hC:    w_dec = 8'hC6;
         4'hD:    w_dec = 8'hA1;
         4'hE:    w_dec = 8'h86;
         default: w_dec = 8'h8E;
      endcase
   end

   // Scan timing, frame-latched shadow, registered display outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scnt   <= '0;
         r_dig    <= '0;
         r_shadow <= '0;
         r_an     <= 8'hFF;
         r_seg    <= 8'hFF;
      end else begin
         r_scnt <= w_scan_wrap ? '0 : r_scnt + 1'b1;
         if (w_scan_wrap) begin
            r_dig <= r_dig + 3'd1;
         end
         if (w_frame_end) begin
            r_shadow <= w_sel;
         end
         r_an  <= ~(8'b1 << r_dig);
         r_seg <= w_dec;
      end
   end

   // A change is accepted only after DEB_CYC consecutive differing samples
   assign w_deb_diff = (r_sync2 != r_btn_s);
   assign w_deb_fire = w_deb_diff && (r_dcnt == DEB_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_btn_s <= 1'b0;
         r_dcnt  <= '0;
         r_addr  <= '0;
      end else begin
         r_sync1 <= addr_up;
         r_sync2 <= r_sync1;
         if (!w_deb_diff || w_deb_fire) begin
            r_dcnt <= '0;
         end else begin
            r_dcnt <= r_dcnt + 1'b1;
         end
         if (w_deb_fire) begin
            r_btn_s <= ~r_btn_s;
         end
         // Press edge only; 4095 wraps to 0 naturally
         if (w_deb_fire && !r_btn_s) begin
            r_addr <= r_addr + 12'd1;
         end
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign addr_debug = r_addr;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan with SCAN_DIV=4, DEB_CYC=3.
module tb_seg_display_scan;

   localparam int SD = 4;
   localparam int DC = 3;
   localparam int FR = 8 * SD;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  mode = 3'd0;
   logic [31:0] syscall_out = 32'h0;
   logic [31:0] pc = 32'h0;
   logic [31:0] memory_out = 32'h0;
   logic [15:0] total_cycles = 16'h0;
   logic [15:0] jump_cycles = 16'h0;
   logic [15:0] branch_cycles = 16'h0;
   logic [15:0] branch_sucess_cycles = 16'h0;
   logic        addr_up = 1'b0;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic [11:0] addr_debug;

   seg_display_scan #(
      .SCAN_DIV(SD),
      .DEB_CYC (DC)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .mode                (mode),
      .syscall_out         (syscall_out),
      .pc                  (pc),
      .memory_out          (memory_out),
      .total_cycles        (total_cycles),
      .jump_cycles         (jump_cycles),
      .branch_cycles       (branch_cycles),
      .branch_sucess_cycles(branch_sucess_cycles),
      .addr_up             (addr_up),
      .an                  (an),
      .seg                 (seg),
      .addr_debug          (addr_debug)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_n = clock edges since reset release; digit and frame follow from it
   // arithmetically. Button acceptance: the last DC synchronized samples
   // (raw delayed two edges) all differ from the accepted level.
   int          m_n = 0;
   logic [31:0] m_sh = 32'h0;
   logic [7:0]  e_an = 8'hFF;
   logic [7:0]  e_seg = 8'hFF;
   logic [11:0] m_addr = 12'h0;
   logic        m_acc = 1'b0;
   logic        h [0:2+DC-1];
   bit          m_valid = 1'b0;

   function automatic logic [31:0] sel_model(input logic [2:0] md, input logic [11:0] a);
      case (md)
         3'd0: return syscall_out;
         3'd1: return pc;
         3'd2: return memory_out;
         3'd3: return {16'h0, total_cycles};
         3'd4: return {16'h0, jump_cycles};
         3'd5: return {16'h0, branch_cycles};
         3'd6: return {16'h0, branch_sucess_cycles};
         default: return {20'h0, a};
      endcase
   endfunction

   task automatic model_step();
      int          d;
      logic [3:0]  nb;
      logic [31:0] sv;
      bit          fire;
      m_valid = 1'b1;
      if (reset) begin
         m_n = 0; m_sh = '0; e_an = 8'hFF; e_seg = 8'hFF; m_addr = '0; m_acc = 1'b0;
         for (int i = 0; i < 2 + DC; i++) h[i] = 1'b0;
      end else begin
         d = (m_n / SD) % 8;
         e_an = ~(8'd1 << d);
         nb = m_sh[4*d +: 4];
         e_seg = dec_tab[nb];
         sv = sel_model(mode, m_addr);
         if (m_n % FR == FR - 1) m_sh = sv;
         for (int i = 2 + DC - 1; i > 0; i--) h[i] = h[i-1];
         h[0] = addr_up;
         fire = 1'b1;
         for (int i = 2; i < 2 + DC; i++) if (h[i] == m_acc) fire = 1'b0;
         if (fire) begin
            m_acc = ~m_acc;
            if (m_acc) m_addr = m_addr + 12'd1;
         end
         m_n++;
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model an", {24'h0, an}, {24'h0, e_an});
         chk("model seg", {24'h0, seg}, {24'h0, e_seg});
         chk("model addr_debug", {20'h0, addr_debug}, {20'h0, m_addr});
      end
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("release an", {24'h0, an}, 32'hFE);
      chk("release seg", {24'h0, seg}, 32'hC0);
   endtask

   // Checks one whole frame against exp. fresh=1 waits for a frame whose
   // shadow was loaded after this call; fresh=0 takes the next frame start
   // (or the current one if already there).
   task automatic frame(input string name, input logic [31:0] exp, input bit fresh,
                        input int chg_at, input logic [2:0] chg_mode);
      int         guard;
      logic [7:0] ea;
      logic [3:0] nb;
      guard = 0;
      if (fresh) begin
         @(negedge clk);
         while (m_n % FR != 0 && guard < 100) begin @(negedge clk); guard++; end
         @(negedge clk);
      end else begin
         while (m_n % FR != 1 && guard < 100) begin @(negedge clk); guard++; end
      end
      if (guard >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL %s: frame start not reached, m_n=%0d", name, m_n);
         return;
      end
      for (int i = 0; i < FR; i++) begin
         if (i > 0) @(negedge clk);
         if (i == chg_at) mode = chg_mode;
         ea = ~(8'd1 << (i / SD));
         nb = exp[4*(i/SD) +: 4];
         chk({name, " an"}, {24'h0, an}, {24'h0, ea});
         chk({name, " seg"}, {24'h0, seg}, {24'h0, dec_tab[nb]});
      end
   endtask

   task automatic press();
      addr_up = 1'b1;
      repeat (6) @(negedge clk);
      addr_up = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   typedef struct {
      logic [2:0]  md;
      logic [31:0] shown;
   } vec_t;

   vec_t vecs [8];

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int first;
      int rl;
      vecs[0] = '{3'd0, 32'h1234ABCD};
      vecs[1] = '{3'd1, 32'h00000040};
      vecs[2] = '{3'd2, 32'hDEADBEEF};
      vecs[3] = '{3'd3, 32'h0000FFFF};
      vecs[4] = '{3'd4, 32'h00000123};
      vecs[5] = '{3'd5, 32'h00004567};
      vecs[6] = '{3'd6, 32'h000089AB};
      vecs[7] = '{3'd7, 32'h00000000};

      // Frame 0 blank, then pc shown
      mode = 3'd1; pc = 32'h0000_0040;
      do_reset();
      frame("f0 blank", 32'h0, 1'b0, -1, 3'd0);
      frame("f1 pc", 32'h0000_0040, 1'b0, -1, 3'd0);

      // Mid-frame mode change does not tear the frame
      mode = 3'd0; syscall_out = 32'h1234ABCD; memory_out = 32'h5A5A_0F0F;
      do_reset();
      frame("f0 blank b", 32'h0, 1'b0, -1, 3'd0);
      frame("f1 syscall", 32'h1234ABCD, 1'b0, 12, 3'd2);
      frame("f2 memory", 32'h5A5A_0F0F, 1'b0, -1, 3'd0);

      // Source select table
      syscall_out = 32'h1234ABCD; pc = 32'h0000_0040; memory_out = 32'hDEADBEEF;
      total_cycles = 16'hFFFF; jump_cycles = 16'h0123; branch_cycles = 16'h4567;
      branch_sucess_cycles = 16'h89AB;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         mode = vecs[k].md;
         frame($sformatf("table mode %0d", vecs[k].md), vecs[k].shown, 1'b1, -1, 3'd0);
      end

      // Short pulse ignored; long press counts once after ~5 cycles
      do_reset();
      addr_up = 1'b1;
      repeat (2) @(negedge clk);
      addr_up = 1'b0;
      repeat (10) @(negedge clk);
      chk("short pulse addr", {20'h0, addr_debug}, 32'd0);
      first = -1;
      addr_up = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (addr_debug == 12'd1 && first < 0) first = i;
      end
      addr_up = 1'b0;
      chk("press latency", first, 32'd5);
      repeat (10) @(negedge clk);
      chk("held press once", {20'h0, addr_debug}, 32'd1);

      // Reset mid-frame (dig=5) and mid-debounce (dcnt=1)
      do_reset();
      while (m_n != 18) @(negedge clk);
      addr_up = 1'b1;
      while (m_n != 21) @(negedge clk);
      reset = 1'b1;
      addr_up = 1'b0;
      @(negedge clk);
      chk("midreset an", {24'h0, an}, 32'hFF);
      chk("midreset seg", {24'h0, seg}, 32'hFF);
      chk("midreset addr", {20'h0, addr_debug}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("postreset an", {24'h0, an}, 32'hFE);
      chk("postreset seg", {24'h0, seg}, 32'hC0);
      repeat (10) @(negedge clk);
      chk("postreset addr", {20'h0, addr_debug}, 32'd0);

      // Address wrap 4095 -> 0, shown with mode 7
      mode = 3'd7;
      do_reset();
      for (int i = 0; i < 4095; i++) press();
      chk("addr 4095", {20'h0, addr_debug}, 32'd4095);
      frame("mode7 fff", 32'h00000FFF, 1'b1, -1, 3'd7);
      press();
      chk("addr wrap", {20'h0, addr_debug}, 32'd0);
      frame("mode7 wrap", 32'h0, 1'b1, -1, 3'd7);

      // Random traffic against the model
      do_reset();
      rl = 1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 39) == 0) mode = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 6))
               0: syscall_out = $urandom;
               1: pc = $urandom;
               2: memory_out = $urandom;
               3: total_cycles = 16'($urandom);
               4: jump_cycles = 16'($urandom);
               5: branch_cycles = 16'($urandom);
               default: branch_sucess_cycles = 16'($urandom);
            endcase
         end
         rl--;
         if (rl == 0) begin
            addr_up = ~addr_up;
            rl = $urandom_range(1, 8);
         end
         reset = ($urandom_range(0, 999) == 0);
      end
      reset = 1'b0;
      addr_up = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
